// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write sequencer (SETUP/PULSE/HOLD/EXEC) driven by an LSU register strobe.
// Define LCD_CTRL_FIFO_EN to add a 4-entry {RS,data} FIFO that buffers writes while busy.
module lcd_ctrl #(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 25,
   parameter int HOLD_CYC  = 2,
   parameter int EXEC_CYC  = 2000,
   parameter int CLEAR_CYC = 82000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_lcd_reg,
   input  logic        i_lcd_wr,
   output logic        o_busy,
   output logic        o_ovf,
   output logic        o_lcd_on,
   output logic        o_lcd_en,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic [7:0]  o_lcd_data
);
   function automatic int eff(int p);
      return (p < 1) ? 1 : p;
   endfunction
   function automatic int maxi(int a, int b);
      return (a > b) ? a : b;
   endfunction
   localparam int MAXP = maxi(maxi(maxi(eff(SETUP_CYC), eff(PULSE_CYC)), maxi(eff(HOLD_CYC), eff(EXEC_CYC))), eff(CLEAR_CYC));
   localparam int CW = $clog2(MAXP + 1);
   // Counter loads are length-1 so that a state lasts exactly its parameter in cycles
   localparam logic [CW-1:0] C_SETUP = CW'(eff(SETUP_CYC) - 1);
   localparam logic [CW-1:0] C_PULSE = CW'(eff(PULSE_CYC) - 1);
   localparam logic [CW-1:0] C_HOLD  = CW'(eff(HOLD_CYC) - 1);
   localparam logic [CW-1:0] C_EXEC  = CW'(eff(EXEC_CYC) - 1);
   localparam logic [CW-1:0] C_CLEAR = CW'(eff(CLEAR_CYC) - 1);
   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;
   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            pop, push, take, drop, load, pending, clear;
   logic [8:0]      head, load_val;
   logic            unused_ok;
   assign unused_ok = ^i_lcd_reg[30:9];
   assign take     = (state == IDLE) && i_lcd_wr && !pop;
   assign drop     = i_lcd_wr && !take && !push;
   assign load     = take || pop;
   assign load_val = pop ? head : i_lcd_reg[8:0];
   assign clear    = !o_lcd_rs && (o_lcd_data[7:2] == 6'd0) && (o_lcd_data[1:0] != 2'd0);
   assign o_busy   = (state != IDLE) || pending;
   assign o_lcd_rw = 1'b0;
`ifdef LCD_CTRL_FIFO_EN
   logic [8:0] fifo [4];
   logic [1:0] rd_ptr, wr_ptr;
   logic [2:0] fcnt;
   assign pending = fcnt != 3'd0;
   assign pop     = (state == IDLE) && pending;
   assign push    = i_lcd_wr && !take && ((fcnt != 3'd4) || pop);
   assign head    = fifo[rd_ptr];
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         fcnt   <= '0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= i_lcd_reg[8:0];
            wr_ptr       <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         fcnt <= fcnt + 3'(push) - 3'(pop);
      end
   end
`else
   assign pending = 1'b0;
   assign pop     = 1'b0;
   assign push    = 1'b0;
   assign head    = '0;
`endif
   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt == '0) ? '0 : cnt - 1'b1;
      case (state)
         IDLE:  if (load) begin
                   state_nxt = SETUP;
                   cnt_nxt   = C_SETUP;
                end
         SETUP: if (cnt == '0) begin
                   state_nxt = PULSE;
                   cnt_nxt   = C_PULSE;
                end
         PULSE: if (cnt == '0) begin
                   state_nxt = HOLD;
                   cnt_nxt   = C_HOLD;
                end
         HOLD:  if (cnt == '0) begin
                   state_nxt = EXEC;
                   cnt_nxt   = clear ? C_CLEAR : C_EXEC;
                end
         EXEC:  if (cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         o_lcd_en   <= 1'b0;
         o_lcd_on   <= 1'b0;
         o_ovf      <= 1'b0;
         o_lcd_rs   <= 1'b0;
         o_lcd_data <= 8'h00;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         o_lcd_en <= state_nxt == PULSE;
         if (i_lcd_wr) o_lcd_on <= i_lcd_reg[31];
         if (drop) o_ovf <= 1'b1;
         if (load) {o_lcd_rs, o_lcd_data} <= load_val;
      end
   end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: table-driven and randomized checks of lcd_ctrl against a transfer-timeline model.
module tb_lcd_ctrl;
   localparam int S = 2, P = 4, H = 2, EX = 10, CLR = 40;
   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [31:0] i_lcd_reg = '0;
   logic        i_lcd_wr = 1'b0;
   logic        o_busy, o_ovf, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
   logic [7:0]  o_lcd_data;
   int nvec = 0, nmis = 0;

   lcd_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .EXEC_CYC(EX), .CLEAR_CYC(CLR)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_lcd_reg(i_lcd_reg), .i_lcd_wr(i_lcd_wr),
      .o_busy(o_busy), .o_ovf(o_ovf), .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en),
      .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data));

   always #5 clk = ~clk;

`ifdef LCD_CTRL_FIFO_EN
   localparam bit FIFO = 1'b1;
`else
   localparam bit FIFO = 1'b0;
`endif

   // Model: each accepted transfer is a start edge plus a length; the panel outputs are
   // derived from where the current edge falls in that window.
   int         m_n = 0, m_a = -1000, m_t = 0;
   logic [8:0] m_cur = '0;
   logic [8:0] m_q[$];
   logic       m_on = 1'b0, m_ovf = 1'b0;
   logic       prev_en = 1'b0;
   logic [7:0] pulses[$];

   function automatic bit is_clear(logic [8:0] v);
      return v[8] == 1'b0 && (v[7:0] == 8'h01 || v[7:0] == 8'h02 || v[7:0] == 8'h03);
   endfunction

   task automatic m_start(input logic [8:0] v);
      m_cur = v;
      m_a   = m_n;
      m_t   = S + P + H + (is_clear(v) ? CLR : EX);
   endtask

   task automatic model_edge(input logic wr, input logic [31:0] r);
      bit idle, popping;
      m_n++;
      if (!i_rst_n) begin
         m_a = -1000; m_t = 0; m_cur = '0; m_q.delete(); m_on = 1'b0; m_ovf = 1'b0;
      end else begin
         idle    = m_n >= m_a + m_t + 1;
         popping = 1'b0;
         if (idle && m_q.size() > 0) begin
            m_start(m_q.pop_front());
            popping = 1'b1;
         end
         if (wr) begin
            m_on = r[31];
            if (idle && !popping) m_start(r[8:0]);
            else if (FIFO && m_q.size() < 4) m_q.push_back(r[8:0]);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, m_n, act, exp);
      end
   endtask

   task automatic check_all();
      chk("en",   32'(o_lcd_en),   32'(m_n >= m_a + S && m_n < m_a + S + P));
      chk("busy", 32'(o_busy),     32'((m_n >= m_a && m_n < m_a + m_t) || m_q.size() > 0));
      chk("rs",   32'(o_lcd_rs),   32'(m_cur[8]));
      chk("data", 32'(o_lcd_data), 32'(m_cur[7:0]));
      chk("on",   32'(o_lcd_on),   32'(m_on));
      chk("ovf",  32'(o_ovf),      32'(m_ovf));
      chk("rw",   32'(o_lcd_rw),   32'd0);
   endtask

   task automatic tick(input logic wr, input logic [31:0] r);
      i_lcd_wr  = wr;
      i_lcd_reg = r;
      @(posedge clk);
      model_edge(wr, r);
      @(negedge clk);
      check_all();
      if (o_lcd_en && !prev_en) pulses.push_back(o_lcd_data);
      prev_en  = o_lcd_en;
      i_lcd_wr = 1'b0;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      tick(1'b0, '0);
      i_rst_n = 1'b1;
      pulses.delete();
   endtask

   task automatic run_idle();
      for (int k = 0; k < 400; k++) begin
         if (!o_busy) break;
         tick(1'b0, '0);
      end
      chk("idle_timeout", 32'(o_busy), 32'd0);
   endtask

   typedef struct {
      logic [31:0] r;
      logic        on;
      logic        rs;
      logic [7:0]  data;
      int          busy;
   } vec_t;

   initial begin
      vec_t vt[7];
      int busy_n, e_first, e_n;
      vt[0] = '{32'h8000_0141, 1'b1, 1'b1, 8'h41, 18};
      vt[1] = '{32'h8000_0001, 1'b1, 1'b0, 8'h01, 48};
      vt[2] = '{32'h0000_0002, 1'b0, 1'b0, 8'h02, 48};
      vt[3] = '{32'h7fff_fe03, 1'b0, 1'b0, 8'h03, 48};
      vt[4] = '{32'h8000_0004, 1'b1, 1'b0, 8'h04, 18};
      vt[5] = '{32'h8000_0101, 1'b1, 1'b1, 8'h01, 18};
      vt[6] = '{32'h0000_0000, 1'b0, 1'b0, 8'h00, 18};

      tick(1'b0, '0);
      tick(1'b0, '0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_data", 32'(o_lcd_data), 32'd0);
      i_rst_n = 1'b1;
      tick(1'b0, '0);

      foreach (vt[i]) begin
         busy_n = 0; e_first = 0; e_n = 0;
         tick(1'b1, vt[i].r);
         chk("tbl_on",   32'(o_lcd_on),   32'(vt[i].on));
         chk("tbl_rs",   32'(o_lcd_rs),   32'(vt[i].rs));
         chk("tbl_data", 32'(o_lcd_data), 32'(vt[i].data));
         for (int k = 1; k <= 200; k++) begin
            if (!o_busy) break;
            busy_n++;
            if (o_lcd_en) begin
               if (e_n == 0) e_first = k;
               e_n++;
            end
            tick(1'b0, '0);
         end
         chk("tbl_busy_len", 32'(busy_n), 32'(vt[i].busy));
         chk("tbl_e_start",  32'(e_first), 32'd3);
         chk("tbl_e_width",  32'(e_n), 32'd4);
      end

      // Second write during PULSE
      do_reset();
      tick(1'b1, 32'h8000_0141);
      tick(1'b0, '0);
      tick(1'b0, '0);
      chk("pulse_en", 32'(o_lcd_en), 32'd1);
      tick(1'b1, 32'h8000_0155);
      run_idle();
      chk("pulse_wr_npulses", 32'(pulses.size()), FIFO ? 32'd2 : 32'd1);
      chk("pulse_wr_ovf", 32'(o_ovf), FIFO ? 32'd0 : 32'd1);
      if (pulses.size() > 0) chk("pulse_wr_first", 32'(pulses[0]), 32'h41);

      // Six back-to-back writes
      do_reset();
      for (int i = 0; i < 6; i++) tick(1'b1, 32'h8000_0130 + 32'(i));
      run_idle();
      chk("b2b_npulses", 32'(pulses.size()), FIFO ? 32'd5 : 32'd1);
      chk("b2b_ovf", 32'(o_ovf), 32'd1);
      foreach (pulses[i]) chk("b2b_order", 32'(pulses[i]), 32'h30 + 32'(i));

      // Last EXEC cycle versus first IDLE cycle
      do_reset();
      tick(1'b1, 32'h8000_0161);
      repeat (17) tick(1'b0, '0);
      chk("last_exec_busy", 32'(o_busy), 32'd1);
      tick(1'b1, 32'h8000_0162);
      chk("last_exec_ovf", 32'(o_ovf), FIFO ? 32'd0 : 32'd1);
      tick(1'b1, 32'h8000_0163);
      run_idle();
      chk("bnd_npulses", 32'(pulses.size()), FIFO ? 32'd3 : 32'd2);
      if (pulses.size() > 1) chk("bnd_last", 32'(pulses[pulses.size() - 1]), 32'h63);

      // Reset during PULSE with writes pending
      do_reset();
      tick(1'b1, 32'h8000_0171);
      tick(1'b1, 32'h8000_0172);
      tick(1'b1, 32'h8000_0173);
      chk("mid_en", 32'(o_lcd_en), 32'd1);
      i_rst_n = 1'b0;
      tick(1'b0, '0);
      chk("mid_rst_en",   32'(o_lcd_en), 32'd0);
      chk("mid_rst_busy", 32'(o_busy), 32'd0);
      chk("mid_rst_on",   32'(o_lcd_on), 32'd0);
      chk("mid_rst_ovf",  32'(o_ovf), 32'd0);
      chk("mid_rst_rsd",  32'({o_lcd_rs, o_lcd_data}), 32'd0);
      i_rst_n = 1'b1;
      pulses.delete();
      repeat (60) tick(1'b0, '0);
      chk("no_resume", 32'(pulses.size()), 32'd0);

      // Random traffic
      for (int it = 0; it < 4000; it++) begin
         logic [31:0] r;
         logic        wr;
         r  = $urandom;
         wr = $urandom_range(0, 11) == 0;
         if ($urandom_range(0, 3) == 0) r[8:0] = {1'b0, 8'($urandom_range(0, 3))};
         i_rst_n = $urandom_range(0, 599) != 0;
         tick(wr, r);
         i_rst_n = 1'b1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
